// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: command encoding, priority encoder and default parameters for the PC sequencer
package pc_seq_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_RESET_VECTOR = 0;
    localparam int DEF_TRAP_VECTOR = 'hF0;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_BRANCH,
        CMD_LOAD,
        CMD_CALL,
        CMD_RET,
        CMD_HALT
    } cmd_t;

    function automatic cmd_t encode_cmd(input logic halt, input logic ret, input logic call,
                                        input logic load, input logic branch, input logic increment);
        return halt ? CMD_HALT : ret ? CMD_RET : call ? CMD_CALL : load ? CMD_LOAD :
               branch ? CMD_BRANCH : increment ? CMD_INC : CMD_HOLD;
    endfunction
endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: LIFO register file indexed by occupancy, no circular overwrite
module pc_return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] depth
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] idx;
    assign idx = depth[AW-1:0];
    assign full = depth == DW'(DEPTH);
    assign empty = depth == '0;
    // at full depth the low bits wrap to 0, so idx-1 still names the top entry
    assign dout = mem[idx - AW'(1)];
    always_ff @(posedge clk or posedge reset)
        if (reset)
            depth <= '0;
        else if (push && !full)
            depth <= depth + DW'(1);
        else if (pop && !empty)
            depth <= depth - DW'(1);
    always_ff @(posedge clk)
        if (push && !full)
            mem[idx] <= din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch, call/ret stack, halt and sticky stack error flags
// PC_SEQ_TRAP_EN: stack errors redirect pc to TRAP_VECTOR instead of target/increment
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               STACK_DEPTH  = DEF_STACK_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEF_TRAP_VECTOR)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         halt,
    input  logic                         increment,
    input  logic                         load,
    input  logic                         branch,
    input  logic                         call,
    input  logic                         ret,
    input  logic [WIDTH-1:0]             target,
    input  logic [7:0]                   offset,
    output logic [WIDTH-1:0]             pc,
    output logic [$clog2(STACK_DEPTH):0] stack_depth,
    output logic                         overflow,
    output logic                         underflow
);
`ifdef PC_SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    cmd_t cmd;
    logic [WIDTH-1:0] pc_inc, off_ext, top, pc_next;
    logic push, pop, full, empty, ov_set, un_set;
    assign cmd = encode_cmd(halt, ret, call, load, branch, increment);
    assign pc_inc = pc + WIDTH'(1);
    // size cast sign-extends the offset, or truncates it when WIDTH < 8
    assign off_ext = WIDTH'($signed(offset));
    always_comb begin
        pc_next = pc;
        push = 1'b0;
        pop = 1'b0;
        ov_set = 1'b0;
        un_set = 1'b0;
        case (cmd)
            CMD_INC:    pc_next = pc_inc;
            CMD_BRANCH: pc_next = pc + off_ext;
            CMD_LOAD:   pc_next = target;
            CMD_CALL: begin
                push = !full;
                ov_set = full;
                pc_next = (full && TRAP_EN) ? TRAP_VECTOR : target;
            end
            CMD_RET: begin
                pop = !empty;
                un_set = empty;
                pc_next = !empty ? top : TRAP_EN ? TRAP_VECTOR : pc_inc;
            end
            default: pc_next = pc;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pc <= RESET_VECTOR;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pc <= pc_next;
            overflow <= overflow | ov_set;
            underflow <= underflow | un_set;
        end
    pc_return_stack #(.WIDTH(WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(pc_inc),
        .dout(top),
        .full(full),
        .empty(empty),
        .depth(stack_depth)
    );
endmodule
